sample_recorder: RTL and testbench

Captures an incoming 8-bit offset-binary audio stream (midpoint 0x80) into on-chip sample RAM, starting automatically when the signal crosses a level threshold after being armed. It is the write-side counterpart of the sample playback path: it fills a buffer that a player or the drum-pad logic later reads back through a registered read port. It sits between the audio input front end (ADC/deserializer delivering `in_valid`/`in_data`) and the sample playback logic.

---
 rtl/sample_recorder.sv | 140 ++++++++++++++
 tb/tb_sample_recorder.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_recorder.sv
// Level-triggered capture of an 8-bit offset-binary stream into sample RAM.
// Buffer is read back through a registered, state-independent read port.
module sample_recorder #(
    parameter int ADDR_W  = 12,
    parameter int MAX_LEN = 4000,
    parameter int THRESH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              armed,
    output logic              recording,
    output logic              done,
    output logic [ADDR_W:0]   rec_len
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LEN_MAX    = MAX_LEN[ADDR_W:0];
    localparam logic [8:0]      THRESH_LVL = THRESH[8:0];

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_RECORD,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   rec_len_q, rec_len_d;
    logic              armed_q, recording_q, done_q;
    logic [7:0]        rd_data_q, rd_data_d;
    logic [7:0]        mem [DEPTH];

    logic [7:0]        magnitude;
    logic              trigger;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;

    // Distance from the 0x80 midpoint; 0x00 maps to 128, which still fits in 8 bits.
    always_comb begin
        if (in_data[7]) begin
            magnitude = in_data - 8'h80;
        end else begin
            magnitude = 8'h80 - in_data;
        end
        trigger = ({1'b0, magnitude} >= THRESH_LVL);
    end

    // The write pointer always equals the number of samples taken so far.
    assign wr_addr = rec_len_q[ADDR_W-1:0];

    always_comb begin
        state_d   = state_q;
        rec_len_d = rec_len_q;
        wr_en     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d   = S_ARMED;
                    rec_len_d = '0;
                end
            end
            S_ARMED: begin
                if (arm) begin
                    state_d = S_IDLE;
                end else if (in_valid && trigger) begin
                    wr_en     = 1'b1;
                    rec_len_d = {{ADDR_W{1'b0}}, 1'b1};
                    state_d   = (rec_len_d == LEN_MAX) ? S_DONE : S_RECORD;
                end
            end
            S_RECORD: begin
                // A sample arriving with a stop command is still kept.
                if (in_valid) begin
                    wr_en     = 1'b1;
                    rec_len_d = rec_len_q + 1'b1;
                end
                if (arm || (rec_len_d == LEN_MAX)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (arm) begin
                    state_d   = S_ARMED;
                    rec_len_d = '0;
                end
            end
            default: begin
                state_d   = S_IDLE;
                rec_len_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rec_len_q   <= '0;
            armed_q     <= 1'b0;
            recording_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rec_len_q   <= rec_len_d;
            armed_q     <= (state_d == S_ARMED);
            recording_q <= (state_d == S_RECORD);
            done_q      <= (state_d == S_DONE);
        end
    end

    // Sample storage is deliberately left without reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= in_data;
        end
    end

    always_comb begin
        rd_data_d = mem[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= 8'h00;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign armed     = armed_q;
    assign recording = recording_q;
    assign done      = done_q;
    assign rec_len   = rec_len_q;

endmodule

// File: tb/tb_sample_recorder.sv
// Self-checking bench for sample_recorder: directed scenarios plus a randomized
// stream compared against a behavioural model of the capture rules.
module tb_sample_recorder;

    localparam int ADDR_W = 5;
    localparam int MAXL   = 16;
    localparam int TH     = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              arm;
    logic              in_valid;
    logic [7:0]        in_data;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              armed;
    logic              recording;
    logic              done;
    logic [ADDR_W:0]   rec_len;

    int n_checks = 0;
    int n_pass   = 0;

    sample_recorder #(
        .ADDR_W (ADDR_W),
        .MAX_LEN(MAXL),
        .THRESH (TH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .arm      (arm),
        .in_valid (in_valid),
        .in_data  (in_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .armed    (armed),
        .recording(recording),
        .done     (done),
        .rec_len  (rec_len)
    );

    always #5 clk = ~clk;

    // Reference model: mode, take length, and a byte array with written-flags.
    typedef enum int {M_IDLE, M_ARMED, M_REC, M_DONE} mode_t;
    mode_t      m_mode;
    int         m_len;
    logic [7:0] m_ram [DEPTH];
    bit         m_known [DEPTH];
    logic [7:0] m_rd;
    bit         m_rd_known;
    logic [7:0] es_samples [6];

    function automatic int level_of(input logic [7:0] d);
        int v;
        v = int'(d);
        return (v >= 128) ? (v - 128) : (128 - v);
    endfunction

    function automatic void model_reset();
        m_mode     = M_IDLE;
        m_len      = 0;
        m_rd       = 8'h00;
        m_rd_known = 1'b1;
    endfunction

    function automatic void model_step(input bit a, input bit v, input logic [7:0] d,
                                       input logic [ADDR_W-1:0] ra);
        m_rd       = m_ram[ra];
        m_rd_known = m_known[ra];
        case (m_mode)
            M_IDLE: begin
                if (a) begin
                    m_mode = M_ARMED;
                    m_len  = 0;
                end
            end
            M_ARMED: begin
                if (a) begin
                    m_mode = M_IDLE;
                end else if (v && level_of(d) >= TH) begin
                    m_ram[0]   = d;
                    m_known[0] = 1'b1;
                    m_len      = 1;
                    m_mode     = (m_len >= MAXL) ? M_DONE : M_REC;
                end
            end
            M_REC: begin
                if (v) begin
                    m_ram[m_len]   = d;
                    m_known[m_len] = 1'b1;
                    m_len          = m_len + 1;
                end
                if (a || m_len >= MAXL) m_mode = M_DONE;
            end
            default: begin
                if (a) begin
                    m_mode = M_ARMED;
                    m_len  = 0;
                end
            end
        endcase
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step(arm, in_valid, in_data, rd_addr);
        #1;
    endtask

    task automatic drive(input bit a, input bit v, input logic [7:0] d);
        arm      = a;
        in_valid = v;
        in_data  = d;
        cycle();
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        arm      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        rd_addr  = '0;
        model_reset();
        #2;
        n_checks++;
        if ({armed, recording, done} !== 3'b000)
            $display("[TB] FAIL reset_flags got %b want 000", {armed, recording, done});
        else n_pass++;
        n_checks++;
        if (rec_len !== '0) $display("[TB] FAIL reset_len got %0d want 0", rec_len);
        else n_pass++;
        n_checks++;
        if (rd_data !== 8'h00) $display("[TB] FAIL reset_rd got %h want 00", rd_data);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, 8'($urandom_range(128, 255)));
            n_checks++;
            if ({armed, recording, done} !== 3'b000 || rec_len !== '0)
                $display("[TB] FAIL idle_stream got flags=%b len=%0d want 000/0",
                         {armed, recording, done}, rec_len);
            else n_pass++;
        end
    endtask

    task automatic test_threshold();
        logic [7:0] quiet [3];
        quiet = '{8'h80, 8'h87, 8'h79};
        drive(1'b1, 1'b0, 8'h00);
        n_checks++;
        if ({armed, recording, done} !== 3'b100 || rec_len !== '0)
            $display("[TB] FAIL arm got flags=%b len=%0d want 100/0", {armed, recording, done}, rec_len);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, quiet[i]);
            n_checks++;
            if ({armed, recording, done} !== 3'b100 || rec_len !== '0)
                $display("[TB] FAIL below_thresh %h got flags=%b len=%0d want 100/0",
                         quiet[i], {armed, recording, done}, rec_len);
            else n_pass++;
        end
        drive(1'b0, 1'b1, 8'h88);
        n_checks++;
        if ({armed, recording, done} !== 3'b010 || rec_len !== 6'd1)
            $display("[TB] FAIL trig_88 got flags=%b len=%0d want 010/1", {armed, recording, done}, rec_len);
        else n_pass++;
        drive(1'b1, 1'b0, 8'h00);
        rd_addr = '0;
        drive(1'b0, 1'b0, 8'h00);
        n_checks++;
        if (rd_data !== 8'h88 || done !== 1'b1)
            $display("[TB] FAIL ram0_88 got rd=%h done=%b want 88/1", rd_data, done);
        else n_pass++;
        drive(1'b1, 1'b0, 8'h00);
        n_checks++;
        if ({armed, recording, done} !== 3'b100 || rec_len !== '0)
            $display("[TB] FAIL rearm got flags=%b len=%0d want 100/0", {armed, recording, done}, rec_len);
        else n_pass++;
        drive(1'b0, 1'b1, 8'h78);
        n_checks++;
        if ({armed, recording, done} !== 3'b010 || rec_len !== 6'd1)
            $display("[TB] FAIL trig_78 got flags=%b len=%0d want 010/1", {armed, recording, done}, rec_len);
        else n_pass++;
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        n_checks++;
        if (rd_data !== 8'h78) $display("[TB] FAIL ram0_78 got %h want 78", rd_data);
        else n_pass++;
    endtask

    task automatic test_full_take();
        rd_addr = '0;
        drive(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 8'(8'h90 + i));
            if (i == 0) begin
                n_checks++;
                if (rd_data !== 8'h78) $display("[TB] FAIL rd_during_wr got %h want 78 (old byte)", rd_data);
                else n_pass++;
            end
            n_checks++;
            if (i < 15) begin
                if ({armed, recording, done} !== 3'b010 || rec_len !== 6'(i + 1))
                    $display("[TB] FAIL ramp_%0d got flags=%b len=%0d want 010/%0d",
                             i, {armed, recording, done}, rec_len, i + 1);
                else n_pass++;
            end else begin
                if ({armed, recording, done} !== 3'b001 || rec_len !== 6'd16)
                    $display("[TB] FAIL full_done got flags=%b len=%0d want 001/16",
                             {armed, recording, done}, rec_len);
                else n_pass++;
            end
        end
        drive(1'b0, 1'b1, 8'hAA);
        n_checks++;
        if ({armed, recording, done} !== 3'b001 || rec_len !== 6'd16)
            $display("[TB] FAIL sample17 got flags=%b len=%0d want 001/16", {armed, recording, done}, rec_len);
        else n_pass++;
        for (int i = 0; i < 16; i++) begin
            rd_addr = ADDR_W'(i);
            drive(1'b0, 1'b0, 8'h00);
            n_checks++;
            if (rd_data !== 8'(8'h90 + i))
                $display("[TB] FAIL ramp_read_%0d got %h want %h", i, rd_data, 8'(8'h90 + i));
            else n_pass++;
        end
    endtask

    task automatic test_early_stop();
        es_samples[0] = 8'h20;
        for (int i = 1; i < 6; i++) es_samples[i] = 8'($urandom);
        drive(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, es_samples[i]);
            n_checks++;
            if (recording !== 1'b1 || rec_len !== 6'(i + 1))
                $display("[TB] FAIL early_%0d got rec=%b len=%0d want 1/%0d", i, recording, rec_len, i + 1);
            else n_pass++;
        end
        drive(1'b1, 1'b1, es_samples[5]);
        n_checks++;
        if ({armed, recording, done} !== 3'b001 || rec_len !== 6'd6)
            $display("[TB] FAIL early_stop got flags=%b len=%0d want 001/6", {armed, recording, done}, rec_len);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            rd_addr = ADDR_W'(i);
            drive(1'b0, 1'b0, 8'h00);
            n_checks++;
            if (rd_data !== es_samples[i])
                $display("[TB] FAIL early_read_%0d got %h want %h", i, rd_data, es_samples[i]);
            else n_pass++;
        end
    endtask

    task automatic test_rearm();
        drive(1'b1, 1'b0, 8'h00);
        n_checks++;
        if ({armed, recording, done} !== 3'b100 || rec_len !== '0)
            $display("[TB] FAIL done_rearm got flags=%b len=%0d want 100/0", {armed, recording, done}, rec_len);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            rd_addr = ADDR_W'(i);
            drive(1'b0, 1'b0, 8'h00);
            n_checks++;
            if (rd_data !== es_samples[i])
                $display("[TB] FAIL kept_read_%0d got %h want %h", i, rd_data, es_samples[i]);
            else n_pass++;
        end
        drive(1'b1, 1'b1, 8'h00);
        n_checks++;
        if ({armed, recording, done} !== 3'b000 || rec_len !== '0)
            $display("[TB] FAIL disarm got flags=%b len=%0d want 000/0", {armed, recording, done}, rec_len);
        else n_pass++;
        rd_addr = '0;
        drive(1'b0, 1'b1, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        n_checks++;
        if ({armed, recording, done} !== 3'b000 || rd_data !== es_samples[0])
            $display("[TB] FAIL disarm_nowrite got flags=%b rd=%h want 000/%h",
                     {armed, recording, done}, rd_data, es_samples[0]);
        else n_pass++;
    endtask

    task automatic test_reset_mid_record();
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 8'hF0);
        drive(1'b0, 1'b1, 8'hE1);
        drive(1'b0, 1'b1, 8'hD2);
        n_checks++;
        if (recording !== 1'b1 || rec_len !== 6'd3)
            $display("[TB] FAIL pre_reset got rec=%b len=%0d want 1/3", recording, rec_len);
        else n_pass++;
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({armed, recording, done} !== 3'b000 || rec_len !== '0 || rd_data !== 8'h00)
            $display("[TB] FAIL async_reset got flags=%b len=%0d rd=%h want 000/0/00",
                     {armed, recording, done}, rec_len, rd_data);
        else n_pass++;
        #2;
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 8'h11);
        n_checks++;
        if ({armed, recording, done} !== 3'b010 || rec_len !== 6'd1)
            $display("[TB] FAIL post_reset_take got flags=%b len=%0d want 010/1", {armed, recording, done}, rec_len);
        else n_pass++;
        drive(1'b1, 1'b0, 8'h00);
        rd_addr = '0;
        drive(1'b0, 1'b0, 8'h00);
        n_checks++;
        if (rd_data !== 8'h11) $display("[TB] FAIL post_reset_ram0 got %h want 11", rd_data);
        else n_pass++;
        rd_addr = ADDR_W'(1);
        drive(1'b0, 1'b0, 8'h00);
        n_checks++;
        if (rd_data !== 8'hE1) $display("[TB] FAIL post_reset_ram1 got %h want e1", rd_data);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] d;
        for (int i = 0; i < 600; i++) begin
            d = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(116, 140)) : 8'($urandom);
            rd_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
            drive(($urandom_range(0, 11) == 0), ($urandom_range(0, 9) < 7), d);
            n_checks++;
            if ({armed, recording, done} !== {m_mode == M_ARMED, m_mode == M_REC, m_mode == M_DONE})
                $display("[TB] FAIL rand_flags_%0d got %b want %b", i, {armed, recording, done},
                         {m_mode == M_ARMED, m_mode == M_REC, m_mode == M_DONE});
            else n_pass++;
            n_checks++;
            if (rec_len !== 6'(m_len))
                $display("[TB] FAIL rand_len_%0d got %0d want %0d", i, rec_len, m_len);
            else n_pass++;
            if (m_rd_known) begin
                n_checks++;
                if (rd_data !== m_rd)
                    $display("[TB] FAIL rand_rd_%0d got %h want %h", i, rd_data, m_rd);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_threshold();
        test_full_take();
        test_early_stop();
        test_rearm();
        test_reset_mid_record();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
